// File: rtl/bidir_serial_port.sv
// Half-duplex serial port: shifts a word out MSB-first on a shared line,
// releases the line for a guard time, or shifts a word in on request.
module bidir_serial_port #(
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    inout  wire              IO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rx_start,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             oe,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [3:0]    TURN_LAST = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_TURN,
        S_RX
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    bitcnt_q;
    logic [CW-1:0]    bitcnt_d;
    logic [3:0]       turncnt_q;
    logic [3:0]       turncnt_d;
    logic [WIDTH-1:0] rxdata_q;
    logic [WIDTH-1:0] rxdata_d;
    logic             rxvalid_q;
    logic             rxvalid_d;

    logic             drive_en;
    logic             io_in;

    // The line is only ever driven while shifting a word out; the enable
    // comes straight from the state register so reset releases it at once.
    assign drive_en = (state_q == S_TX);
    assign IO       = drive_en ? shreg_q[WIDTH-1] : 1'bz;
    assign io_in    = IO;

    assign oe       = drive_en;
    assign busy     = (state_q != S_IDLE);
    assign tx_ready = (state_q == S_IDLE) && ASYNCRESETN;
    assign rx_data  = rxdata_q;
    assign rx_valid = rxvalid_q;

    // State, shift register, counters and receive result registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            turncnt_q <= '0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            turncnt_q <= turncnt_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
        end
    end

    // Next-state logic; a transmit request beats a receive request in IDLE
    // and requests arriving in any other state are simply not looked at.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        turncnt_d = turncnt_q;
        rxdata_d  = rxdata_q;
        rxvalid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bitcnt_d  = '0;
                turncnt_d = '0;
                if (tx_valid) begin
                    shreg_d = tx_data;
                    state_d = S_TX;
                end else if (rx_start) begin
                    shreg_d = '0;
                    state_d = S_RX;
                end
            end
            S_TX: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bitcnt_q == BIT_LAST) begin
                    bitcnt_d = '0;
                    state_d  = (TURN == 0) ? S_IDLE : S_TURN;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            S_TURN: begin
                if (turncnt_q == TURN_LAST) begin
                    turncnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    turncnt_d = turncnt_q + 4'd1;
                end
            end
            S_RX: begin
                shreg_d = {shreg_q[WIDTH-2:0], io_in};
                if (bitcnt_q == BIT_LAST) begin
                    bitcnt_d  = '0;
                    rxdata_d  = {shreg_q[WIDTH-2:0], io_in};
                    rxvalid_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bidir_serial_port.sv
// Bench for bidir_serial_port: directed and random words checked against
// a bit-level model of the line built from the word values.
module tb_bidir_serial_port;

    localparam int W = 8;
    localparam int T = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n;

    wire          a_io;
    logic         tb_en;
    logic         tb_bit;
    logic [W-1:0] a_txd;
    logic         a_txv;
    logic         a_rdy;
    logic         a_rxs;
    logic [W-1:0] a_rxd;
    logic         a_rxv;
    logic         a_oe;
    logic         a_busy;

    assign a_io = tb_en ? tb_bit : 1'bz;

    wire          b_io;
    logic [W-1:0] b_txd;
    logic         b_txv;
    logic         b_rdy;
    logic         b_rxs;
    logic [W-1:0] b_rxd;
    logic         b_rxv;
    logic         b_oe;
    logic         b_busy;

    int           checks;
    int           errors;
    logic [W-1:0] ref_rx;

    bidir_serial_port #(.WIDTH(W), .TURN(T)) dut_a (
        .CLK        (CLK),
        .ASYNCRESETN(rst_n),
        .IO         (a_io),
        .tx_data    (a_txd),
        .tx_valid   (a_txv),
        .tx_ready   (a_rdy),
        .rx_start   (a_rxs),
        .rx_data    (a_rxd),
        .rx_valid   (a_rxv),
        .oe         (a_oe),
        .busy       (a_busy)
    );

    bidir_serial_port #(.WIDTH(W), .TURN(0)) dut_b (
        .CLK        (CLK),
        .ASYNCRESETN(rst_n),
        .IO         (b_io),
        .tx_data    (b_txd),
        .tx_valid   (b_txv),
        .tx_ready   (b_rdy),
        .rx_start   (b_rxs),
        .rx_data    (b_rxd),
        .rx_valid   (b_rxv),
        .oe         (b_oe),
        .busy       (b_busy)
    );

    function automatic logic bit_of(input logic [W-1:0] w, input int i);
        return 1'((32'(w) >> i) & 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_word(input logic [W-1:0] w, input bit with_rx);
        @(negedge CLK);
        chk("tx_ready_idle", 32'(a_rdy), 32'd1);
        tb_en = 1'b0;
        a_txd = w;
        a_txv = 1'b1;
        a_rxs = with_rx;
        @(posedge CLK);
        #1;
        a_txv = 1'b0;
        a_rxs = 1'b0;
        a_txd = W'($urandom);
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            chk("tx_oe", 32'(a_oe), 32'd1);
            chk("tx_bit", 32'(a_io), 32'(bit_of(w, W - 1 - k)));
            chk("tx_busy", 32'(a_busy), 32'd1);
            chk("tx_ready_busy", 32'(a_rdy), 32'd0);
            chk("tx_rxv", 32'(a_rxv), 32'd0);
            if (k == 2) begin
                a_txv = 1'b1;
                a_rxs = 1'b1;
            end
            if (k == 4) begin
                a_txv = 1'b0;
                a_rxs = 1'b0;
            end
        end
        tb_en  = 1'b1;
        tb_bit = 1'b0;
        for (int k = 0; k < T; k++) begin
            @(negedge CLK);
            chk("turn_oe", 32'(a_oe), 32'd0);
            chk("turn_io", 32'(a_io), 32'd0);
            chk("turn_busy", 32'(a_busy), 32'd1);
            chk("turn_ready", 32'(a_rdy), 32'd0);
        end
        @(negedge CLK);
        chk("post_tx_ready", 32'(a_rdy), 32'd1);
        chk("post_tx_busy", 32'(a_busy), 32'd0);
        chk("post_tx_oe", 32'(a_oe), 32'd0);
        chk("post_tx_rxv", 32'(a_rxv), 32'd0);
        chk("post_tx_rxd", 32'(a_rxd), 32'(ref_rx));
    endtask

    task automatic rx_word(input logic [W-1:0] w);
        @(negedge CLK);
        chk("rx_ready_idle", 32'(a_rdy), 32'd1);
        a_rxs  = 1'b1;
        a_txv  = 1'b0;
        tb_en  = 1'b1;
        tb_bit = 1'($urandom);
        @(posedge CLK);
        #1;
        a_rxs  = 1'b0;
        tb_bit = bit_of(w, W - 1);
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            chk("rx_oe", 32'(a_oe), 32'd0);
            chk("rx_busy", 32'(a_busy), 32'd1);
            chk("rx_rxv", 32'(a_rxv), 32'd0);
            chk("rx_held", 32'(a_rxd), 32'(ref_rx));
            if (k == 3) begin
                a_txv = 1'b1;
                a_txd = W'($urandom);
            end
            if (k == 5) a_txv = 1'b0;
            @(posedge CLK);
            #1;
            if (k < W - 1) tb_bit = bit_of(w, W - 2 - k);
            else tb_bit = 1'($urandom);
        end
        ref_rx = w;
        @(negedge CLK);
        chk("rx_valid_pulse", 32'(a_rxv), 32'd1);
        chk("rx_data", 32'(a_rxd), 32'(w));
        chk("rx_done_busy", 32'(a_busy), 32'd0);
        chk("rx_done_ready", 32'(a_rdy), 32'd1);
        @(negedge CLK);
        chk("rx_valid_one", 32'(a_rxv), 32'd0);
        chk("rx_data_hold", 32'(a_rxd), 32'(w));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ref_rx = '0;
        rst_n  = 1'b1;
        tb_en  = 1'b1;
        tb_bit = 1'b0;
        a_txd  = 8'hA5;
        a_txv  = 1'b1;
        a_rxs  = 1'b0;
        b_txd  = '0;
        b_txv  = 1'b0;
        b_rxs  = 1'b0;
        #2 rst_n = 1'b0;

        repeat (4) begin
            @(negedge CLK);
            chk("rst_oe", 32'(a_oe), 32'd0);
            chk("rst_io", 32'(a_io), 32'd0);
            chk("rst_ready", 32'(a_rdy), 32'd0);
            chk("rst_rxd", 32'(a_rxd), 32'd0);
            chk("rst_rxv", 32'(a_rxv), 32'd0);
            chk("rst_busy", 32'(a_busy), 32'd0);
        end
        a_txv = 1'b0;
        @(posedge CLK);
        #1 rst_n = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", 32'(a_rdy), 32'd1);
        chk("busy_after_rst", 32'(a_busy), 32'd0);

        tx_word(8'hA5, 1'b0);
        rx_word(8'h3C);
        tx_word(8'h81, 1'b1);
        chk("prio_no_rx", 32'(a_rxd), 32'h3C);

        repeat (10) begin
            if ($urandom_range(1, 0) == 1) tx_word(W'($urandom), 1'b0);
            else rx_word(W'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge CLK);
        end

        @(negedge CLK);
        tb_en = 1'b0;
        a_txd = 8'h5A;
        a_txv = 1'b1;
        @(posedge CLK);
        #1 a_txv = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk("midtx_driving", 32'(a_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midtx_rst_oe", 32'(a_oe), 32'd0);
        chk("midtx_rst_busy", 32'(a_busy), 32'd0);
        chk("midtx_rst_ready", 32'(a_rdy), 32'd0);
        tb_en  = 1'b1;
        tb_bit = 1'b0;
        #1;
        chk("midtx_rst_io", 32'(a_io), 32'd0);
        ref_rx = '0;
        chk("midtx_rst_rxd", 32'(a_rxd), 32'd0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        @(negedge CLK);
        chk("midtx_ready", 32'(a_rdy), 32'd1);
        tx_word(8'h0F, 1'b0);

        rx_word(8'h96);
        @(negedge CLK);
        a_rxs = 1'b1;
        tb_en = 1'b1;
        @(posedge CLK);
        #1;
        a_rxs = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tb_bit = bit_of(8'hC3, W - 1 - k);
            @(posedge CLK);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        ref_rx = '0;
        chk("midrx_rst_rxd", 32'(a_rxd), 32'd0);
        chk("midrx_rst_rxv", 32'(a_rxv), 32'd0);
        chk("midrx_rst_busy", 32'(a_busy), 32'd0);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("midrx_no_rxv", 32'(a_rxv), 32'd0);
            chk("midrx_rxd_zero", 32'(a_rxd), 32'd0);
            chk("midrx_idle", 32'(a_busy), 32'd0);
        end
        rx_word(W'($urandom));

        @(negedge CLK);
        b_txd = 8'hFF;
        b_txv = 1'b1;
        @(posedge CLK);
        #1 b_txd = 8'h00;
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            chk("b2b_oe_ones", 32'(b_oe), 32'd1);
            chk("b2b_ones", 32'(b_io), 32'd1);
        end
        @(negedge CLK);
        chk("b2b_gap_oe", 32'(b_oe), 32'd0);
        chk("b2b_gap_ready", 32'(b_rdy), 32'd1);
        @(posedge CLK);
        #1 b_txv = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            chk("b2b_oe_zeros", 32'(b_oe), 32'd1);
            chk("b2b_zeros", 32'(b_io), 32'd0);
        end
        @(negedge CLK);
        chk("b2b_end_oe", 32'(b_oe), 32'd0);
        chk("b2b_end_busy", 32'(b_busy), 32'd0);
        chk("b2b_no_rxv", 32'(b_rxv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
